pheap_sched: RTL and testbench
==============================

# pheap_sched

Front-end scheduler for the pipelined heap priority queue. Arbitrates round-robin between two requesters issuing enqueue (LEQ) or dequeue (DEQ) operations and sequences the accepted operation into the level-1 controller. Tracks occupancy so that operations on a full or empty heap are rejected without touching the pipeline. Returns each result on a single shared response channel with ready/valid handshake.

## Interface
- LEVELS, 4, heap depth; capacity CAP = 2^LEVELS − 1 entries
- PW, 32, priority value width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_op / req1_op  in  pheapTypes::opcode_t  LEQ or DEQ
- req0_value / req1_value  in  PW  priority to enqueue (ignored for DEQ)
- req0_ready / req1_ready  out  1  grant; request consumed in the cycle valid && ready
- l1_start  out  1  one-cycle start pulse to level 1
- l1_op  out  pheapTypes::opcode_t  operation to level 1, held from ISSUE through EXEC
- l1_in  out  PW  value to level 1, held from ISSUE through EXEC
- l1_out  in  PW  level-1 result, sampled in EXEC
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_err  out  1  operation rejected (ENQ on full, DEQ on empty)
- rsp_value  out  PW  dequeued value; 0 for ENQ or error
- count  out  LEVELS  current occupancy, 0..CAP
- full / empty  out  1  count==CAP / count==0
- stat_issued / stat_rejected  out  16  statistics counters (see Configuration)

## Operation
- States: IDLE, ISSUE, EXEC, RESP.
- IDLE: if any req valid, grant one (ready high combinationally, this cycle only). Round-robin: pointer `last` holds index of previous grant; on both valid, grant !last. `last` updates on each grant.
- On grant, latch id, op, value. If (op==LEQ && full) or (op==DEQ && empty): rsp_err=1, rsp_value=0, go RESP. Otherwise go ISSUE.
- ISSUE: l1_start=1, l1_op/l1_in driven from latched request; go EXEC.
- EXEC: level 1 in its output phase; capture rsp_value = (op==DEQ) ? l1_out : 0; rsp_err=0; update count (+1 LEQ, −1 DEQ); go RESP.
- RESP: rsp_valid=1, rsp_id/err/value stable; stay until rsp_ready; on handshake go IDLE. No grant while not IDLE.
- count never wraps: LEQ only issued when count<CAP, DEQ only when count>0.
- Scheduler never clears heap memories; system reset resets both.

## Timing
- Reset values: state IDLE, all ready 0, l1_start 0, l1_op LEQ, l1_in 0, rsp_valid 0, rsp_id 0, rsp_err 0, rsp_value 0, count 0, full 0, empty 1, `last` 1 (requester 0 wins first tie), stats 0.
- Accepted op: grant cycle T (IDLE), l1_start at T+1, l1_out sampled end of T+2, rsp_valid from T+3. Minimum 4 cycles per accepted op including RESP handshake cycle.
- Rejected op: grant at T, rsp_valid from T+1; no l1_start.
- count/full/empty update at end of EXEC, visible T+3.
- rsp_* registered, stable while rsp_valid && !rsp_ready.
- Async reset mid-operation: all registers to reset values immediately; in-flight op and pending response dropped; l1_start deasserts without waiting for clock.

## Configuration
- PHEAP_SCHED_STATS_EN defined: stat_issued increments at each ISSUE, stat_rejected at each rejected grant; both 16-bit, saturate at 0xFFFF, reset to 0.
- Undefined: counters not built; stat_issued and stat_rejected tied to 0. Ports present in both builds.

## Test plan
- Reset, req0 LEQ 5 -> req0_ready at T, l1_start at T+1 with l1_in=5, rsp_valid T+3 with id=0, err=0, value=0, count=1.
- count=1, req1 DEQ, l1_out=5 in EXEC -> rsp id=1, err=0, value=5; count=0, empty=1.
- Empty heap, DEQ -> rsp_valid at T+1, err=1, value=0, no l1_start, stat_rejected=1 (STATS_EN).
- LEVELS=2, fill with 3 LEQ, fourth LEQ -> err=1, count stays 3, full=1.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1; rsp_ready held low 5 cycles -> rsp fields stable, no new grant.
- Assert rst during EXEC -> outputs at reset values before next edge; count 0; following LEQ completes normally.

Source files
------------

// File: rtl/pheap_sched.sv
// pheap_sched: round-robin front-end scheduler for the pipelined heap priority queue.
// Statistics counters are built only when PHEAP_SCHED_STATS_EN is defined.
package pheapTypes;
  typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;
endpackage

module pheap_sched #(
  parameter int LEVELS = 4,
  parameter int PW     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  pheapTypes::opcode_t req0_op,
  input  logic [PW-1:0]       req0_value,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  pheapTypes::opcode_t req1_op,
  input  logic [PW-1:0]       req1_value,
  output logic                req1_ready,
  output logic                l1_start,
  output pheapTypes::opcode_t l1_op,
  output logic [PW-1:0]       l1_in,
  input  logic [PW-1:0]       l1_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic                rsp_err,
  output logic [PW-1:0]       rsp_value,
  output logic [LEVELS-1:0]   count,
  output logic                full,
  output logic                empty,
  output logic [15:0]         stat_issued,
  output logic [15:0]         stat_rejected
);
  import pheapTypes::*;

  localparam logic [LEVELS-1:0] CAP = {LEVELS{1'b1}};
  localparam logic [LEVELS-1:0] ONE = LEVELS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

  state_t        state, state_nx;
  logic          last;
  opcode_t       op_q;
  logic [PW-1:0] val_q;
  logic          gnt_any, gnt_id, reject;
  opcode_t       sel_op;
  logic [PW-1:0] sel_val;

  assign full      = (count == CAP);
  assign empty     = (count == '0);
  assign l1_start  = (state == ISSUE);
  assign l1_op     = op_q;
  assign l1_in     = val_q;
  assign rsp_valid = (state == RESP);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    sel_op     = gnt_id ? req1_op : req0_op;
    sel_val    = gnt_id ? req1_value : req0_value;
    reject     = (sel_op == LEQ && full) || (sel_op == DEQ && empty);
    req0_ready = gnt_any && !gnt_id;
    req1_ready = gnt_any && gnt_id;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = reject ? RESP : ISSUE;
      ISSUE:   state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      op_q      <= LEQ;
      val_q     <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_value <= '0;
      count     <= '0;
    end else begin
      state <= state_nx;
      if (gnt_any) begin
        last      <= gnt_id;
        op_q      <= sel_op;
        val_q     <= sel_val;
        rsp_id    <= gnt_id;
        rsp_err   <= reject;
        rsp_value <= '0;
      end
      if (state == EXEC) begin
        rsp_err   <= 1'b0;
        rsp_value <= (op_q == DEQ) ? l1_out : '0;
        count     <= (op_q == LEQ) ? count + ONE : count - ONE;
      end
    end
  end

`ifdef PHEAP_SCHED_STATS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued   <= '0;
      stat_rejected <= '0;
    end else begin
      if (state == ISSUE && stat_issued != 16'hFFFF)
        stat_issued <= stat_issued + 16'd1;
      if (gnt_any && reject && stat_rejected != 16'hFFFF)
        stat_rejected <= stat_rejected + 16'd1;
    end
  end
`else
  assign stat_issued   = '0;
  assign stat_rejected = '0;
`endif

endmodule

// File: tb/tb_pheap_sched.sv
// Self-checking bench for pheap_sched: scoreboarded responses, cycle timing, arbitration, reset.
// A behavioural level-1 stand-in supplies l1_out from its own copy of the heap contents.
module tb_pheap_sched;
  import pheapTypes::*;

  localparam int LEVELS = 2;
  localparam int PW     = 32;
  localparam int CAP    = (1 << LEVELS) - 1;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [PW-1:0] value;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  opcode_t           req0_op, req1_op, l1_op;
  logic [PW-1:0]     req0_value, req1_value, l1_in, l1_out, rsp_value;
  logic              l1_start, rsp_valid, rsp_ready, rsp_id, rsp_err, full, empty;
  logic [LEVELS-1:0] count;
  logic [15:0]       stat_issued, stat_rejected;

  int            errors = 0;
  int            checks = 0;
  rsp_t          sb[$];
  logic [PW-1:0] mheap[$];
  int            mcount, m_iss, m_rej;
  logic [PW-1:0] l1q[$];
  int            start_cnt;

  pheap_sched #(.LEVELS(LEVELS), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_value(req0_value), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_value(req1_value), .req1_ready(req1_ready),
    .l1_start(l1_start), .l1_op(l1_op), .l1_in(l1_in), .l1_out(l1_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_value(rsp_value), .count(count), .full(full), .empty(empty),
    .stat_issued(stat_issued), .stat_rejected(stat_rejected)
  );

  always #5 clk = ~clk;

  function automatic int min_idx(input logic [PW-1:0] q[$]);
    int mi = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] < q[mi]) mi = i;
    return mi;
  endfunction

  // Level-1 stand-in: result of a DEQ appears on l1_out during EXEC.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      l1q.delete();
      l1_out    <= '0;
      start_cnt <= 0;
    end else if (l1_start) begin
      start_cnt <= start_cnt + 1;
      if (l1_op == LEQ) l1q.push_back(l1_in);
      else if (l1q.size() > 0) begin
        l1_out <= l1q[min_idx(l1q)];
        l1q.delete(min_idx(l1q));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    mheap.delete();
    mcount = 0;
    m_iss  = 0;
    m_rej  = 0;
  endtask

  task automatic sb_push(input logic id, input opcode_t op, input logic [PW-1:0] v);
    rsp_t e;
    int mi;
    e.id = id;
    if ((op == LEQ && mcount == CAP) || (op == DEQ && mcount == 0)) begin
      e.err = 1'b1; e.value = '0; m_rej++;
    end else begin
      e.err = 1'b0; m_iss++;
      if (op == LEQ) begin
        e.value = '0; mheap.push_back(v); mcount++;
      end else begin
        mi = min_idx(mheap);
        e.value = mheap[mi]; mheap.delete(mi); mcount--;
      end
    end
    sb.push_back(e);
  endtask

  task automatic set_req(input logic id, input logic v, input opcode_t op, input logic [PW-1:0] val);
    if (id) begin req1_valid = v; req1_op = op; req1_value = val; end
    else    begin req0_valid = v; req0_op = op; req0_value = val; end
  endtask

  // Present one request, wait (bounded) for its grant, record expectation, then withdraw it.
  task automatic issue(input logic id, input opcode_t op, input logic [PW-1:0] val, output bit granted);
    granted = 1'b0;
    set_req(id, 1'b1, op, val);
    for (int i = 0; i < 10; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        granted = 1'b1;
        sb_push(id, op, val);
        break;
      end
      tick();
    end
    tick();
    set_req(id, 1'b0, LEQ, '0);
  endtask

  // Wait (bounded) for a response, capture it, and complete the handshake.
  task automatic take_rsp(output rsp_t got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      got = '{rsp_id, rsp_err, rsp_value};
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({req0_ready, req1_ready, l1_start, rsp_valid, rsp_id, rsp_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got r0=%b r1=%b start=%b valid=%b id=%b err=%b, want all 0",
               req0_ready, req1_ready, l1_start, rsp_valid, rsp_id, rsp_err);
    end
    checks++;
    if (l1_op !== LEQ || l1_in !== '0 || rsp_value !== '0) begin
      errors++;
      $display("FAIL reset_data: got l1_op=%0d l1_in=%0d rsp_value=%0d, want 0 0 0", l1_op, l1_in, rsp_value);
    end
    checks++;
    if (count !== '0 || full !== 1'b0 || empty !== 1'b1 || stat_issued !== '0 || stat_rejected !== '0) begin
      errors++;
      $display("FAIL reset_count: got count=%0d full=%b empty=%b iss=%0d rej=%0d, want 0 0 1 0 0",
               count, full, empty, stat_issued, stat_rejected);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_enq_timing();
    rsp_t got, exp;
    bit ok;
    set_req(0, 1'b1, LEQ, 32'd5);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL enq_grant: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    sb_push(0, LEQ, 32'd5);
    tick();
    set_req(0, 1'b0, LEQ, '0);
    checks++;
    if (l1_start !== 1'b1 || l1_op !== LEQ || l1_in !== 32'd5 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL enq_issue: got start=%b op=%0d in=%0d r0=%b, want 1 0 5 0", l1_start, l1_op, l1_in, req0_ready);
    end
    tick();
    checks++;
    if (l1_start !== 1'b0 || rsp_valid !== 1'b0 || l1_in !== 32'd5) begin
      errors++;
      $display("FAIL enq_exec: got start=%b valid=%b in=%0d, want 0 0 5", l1_start, rsp_valid, l1_in);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || count !== LEVELS'(1) || empty !== 1'b0) begin
      errors++;
      $display("FAIL enq_resp_time: got valid=%b count=%0d empty=%b, want 1 1 0", rsp_valid, count, empty);
    end
    take_rsp(got, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL enq_rsp: got id=%0d err=%0d value=%0d, want id=%0d err=%0d value=%0d",
               got.id, got.err, got.value, exp.id, exp.err, exp.value);
    end
  endtask

  task automatic test_deq();
    rsp_t got, exp;
    bit ok, g;
    issue(1, DEQ, '0, g);
    take_rsp(got, ok);
    exp = sb.pop_front();
    checks++;
    if (!g || !ok || got !== exp) begin
      errors++;
      $display("FAIL deq_rsp: got grant=%b id=%0d err=%0d value=%0d, want id=%0d err=%0d value=%0d",
               g, got.id, got.err, got.value, exp.id, exp.err, exp.value);
    end
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL deq_count: got count=%0d empty=%b, want 0 1", count, empty);
    end
  endtask

  task automatic test_reject_empty();
    rsp_t got, exp;
    bit ok;
    int sc;
    logic [15:0] exp_rej;
    sc = start_cnt;
    set_req(0, 1'b1, DEQ, '0);
    #1;
    if (req0_ready === 1'b1) sb_push(0, DEQ, '0);
    tick();
    set_req(0, 1'b0, LEQ, '0);
    checks++;
    if (rsp_valid !== 1'b1 || l1_start !== 1'b0) begin
      errors++;
      $display("FAIL rej_time: got valid=%b start=%b at T+1, want 1 0", rsp_valid, l1_start);
    end
    take_rsp(got, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 1'b1, '0};
    checks++;
    if (!ok || got !== exp || got.err !== 1'b1) begin
      errors++;
      $display("FAIL rej_rsp: got id=%0d err=%0d value=%0d, want id=0 err=1 value=0", got.id, got.err, got.value);
    end
    checks++;
    if (start_cnt !== sc) begin
      errors++;
      $display("FAIL rej_no_start: got %0d start pulses, want %0d", start_cnt, sc);
    end
`ifdef PHEAP_SCHED_STATS_EN
    exp_rej = 16'(m_rej);
`else
    exp_rej = 16'd0;
`endif
    checks++;
    if (stat_rejected !== exp_rej) begin
      errors++;
      $display("FAIL rej_stat: got %0d, want %0d", stat_rejected, exp_rej);
    end
  endtask

  task automatic test_full();
    rsp_t got, exp;
    bit ok, g;
    logic [PW-1:0] vals [4] = '{32'd9, 32'd3, 32'd7, 32'd1};
    for (int i = 0; i < 4; i++) begin
      issue(1'(i), LEQ, vals[i], g);
      take_rsp(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      checks++;
      if (!g || !ok || got !== exp) begin
        errors++;
        $display("FAIL fill_%0d: got id=%0d err=%0d value=%0d, want id=%0d err=%0d value=%0d",
                 i, got.id, got.err, got.value, exp.id, exp.err, exp.value);
      end
    end
    checks++;
    if (count !== LEVELS'(CAP) || full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got count=%0d full=%b empty=%b, want %0d 1 0", count, full, empty, CAP);
    end
  endtask

  task automatic test_round_robin();
    rsp_t got, exp, snap;
    bit ok, g, stable;
    logic gid;
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    set_req(0, 1'b1, LEQ, 32'd11);
    set_req(1, 1'b1, LEQ, 32'd22);
    for (int n = 0; n < 4; n++) begin
      g = 1'b0;
      gid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin g = 1'b1; gid = req1_ready; break; end
        tick();
      end
      checks++;
      if (!g || gid !== 1'(n)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got granted=%b id=%0d, want id=%0d", n, g, gid, n % 2);
      end
      if (g) sb_push(gid, LEQ, gid ? 32'd22 : 32'd11);
      tick();
      if (n == 0) begin
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) tick();
        snap = '{rsp_id, rsp_err, rsp_value};
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tick();
          if (rsp_valid !== 1'b1 || '{rsp_id, rsp_err, rsp_value} !== snap ||
              req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
          errors++;
          $display("FAIL rr_hold: got unstable response or grant while stalled, want stable and no grant");
        end
      end
      take_rsp(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL rr_rsp_%0d: got id=%0d err=%0d value=%0d, want id=%0d err=%0d value=%0d",
                 n, got.id, got.err, got.value, exp.id, exp.err, exp.value);
      end
    end
    set_req(0, 1'b0, LEQ, '0);
    set_req(1, 1'b0, LEQ, '0);
  endtask

  task automatic test_reset_mid();
    rsp_t got, exp;
    bit ok, g;
    logic [15:0] exp_iss;
    set_req(0, 1'b1, DEQ, '0);
    tick();
    set_req(0, 1'b0, LEQ, '0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (l1_start !== 1'b0 || rsp_valid !== 1'b0 || l1_op !== LEQ || l1_in !== '0 ||
        count !== '0 || empty !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got start=%b valid=%b op=%0d in=%0d count=%0d empty=%b, want 0 0 0 0 0 1",
               l1_start, rsp_valid, l1_op, l1_in, count, empty);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    issue(0, LEQ, 32'd42, g);
    take_rsp(got, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    checks++;
    if (!g || !ok || got !== exp || count !== LEVELS'(1)) begin
      errors++;
      $display("FAIL post_reset: got id=%0d err=%0d value=%0d count=%0d, want id=%0d err=%0d value=%0d count=1",
               got.id, got.err, got.value, count, exp.id, exp.err, exp.value);
    end
`ifdef PHEAP_SCHED_STATS_EN
    exp_iss = 16'(m_iss);
`else
    exp_iss = 16'd0;
`endif
    checks++;
    if (stat_issued !== exp_iss) begin
      errors++;
      $display("FAIL stat_issued: got %0d, want %0d", stat_issued, exp_iss);
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, LEQ, '0);
    set_req(1, 1'b0, LEQ, '0);
    test_reset();
    test_enq_timing();
    test_deq();
    test_reject_empty();
    test_full();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
